// File: rtl/redmule_tcdm_dedup_window_if.sv
// Flat single-channel HCI-style TCDM bus: request channel plus load response.
// master drives requests and accepts responses; slave is the opposite side.
interface redmule_tcdm_dedup_window_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   localparam int BW = DW / 8;

   logic          req;
   logic          gnt;
   logic [AW-1:0] add;
   logic          wen;
   logic [DW-1:0] data;
   logic [BW-1:0] be;
   logic          r_valid;
   logic          r_ready;
   logic [DW-1:0] r_data;

   modport master (
      output req, add, wen, data, be, r_ready,
      input  gnt, r_valid, r_data
   );

   modport slave (
      input  req, add, wen, data, be, r_ready,
      output gnt, r_valid, r_data
   );
endinterface

// File: rtl/redmule_tcdm_dedup_window.sv
// TCDM request deduplicator: drops stores identical to a recent one and
// repeated loads of the last granted address, replaying the previous load
// data for dropped loads. Bounds loads in flight and keeps responses in order.
module redmule_tcdm_dedup_window #(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int HIST_DEPTH      = 4,
   parameter bit DEDUP_STORES    = 1'b1,
   parameter bit DEDUP_LOADS     = 1'b1,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                enable_i,
   input  logic                                flush_i,
   input  logic                                clear_cnt_i,
   redmule_tcdm_dedup_window_if.slave          tgt,
   redmule_tcdm_dedup_window_if.master         ini,
   output logic [31:0]                         drop_cnt_o,
   output logic                                busy_o
);
   localparam int BW = DW / 8;
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;

   // history window, entry 0 is the youngest granted request
   logic [HIST_DEPTH-1:0] hist_valid;
   logic [AW-1:0]         hist_add  [HIST_DEPTH];
   logic                  hist_wen  [HIST_DEPTH];
   logic [DW-1:0]         hist_data [HIST_DEPTH];
   logic [BW-1:0]         hist_be   [HIST_DEPTH];

   logic          match_found;
   logic          match_wen;
   logic [DW-1:0] match_data;
   logic [BW-1:0] match_be;
   logic          store_drop, load_drop, drop, stall, gnt, handshake;
   logic          hist_clr, hist_push;

   // tag FIFO: one bit per granted load, 1 = answer by replay
   logic [MAX_OUTSTANDING-1:0] tag_mem;
   logic [PW-1:0]              tag_wptr, tag_rptr;
   logic [CW-1:0]              tag_cnt;
   logic                       tag_empty, tag_full, tag_head, tag_push;

   // response buffer for downstream load data
   logic [DW-1:0] rbuf_mem [MAX_OUTSTANDING];
   logic [PW-1:0] rbuf_wptr, rbuf_rptr;
   logic [CW-1:0] rbuf_cnt;
   logic          rbuf_empty, rbuf_full, rbuf_push, rbuf_pop;

   logic          r_valid, resp_hs;
   logic [DW-1:0] r_data;
   logic [DW-1:0] last_data_q;

   assign ini.add     = tgt.add;
   assign ini.wen     = tgt.wen;
   assign ini.data    = tgt.data;
   assign ini.be      = tgt.be;
   assign ini.r_ready = 1'b1;

   // youngest valid same-address entry wins: scan oldest to youngest
   always_comb begin
      match_found = 1'b0;
      match_wen   = 1'b0;
      match_data  = '0;
      match_be    = '0;
      for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
         if (hist_valid[i] && hist_add[i] == tgt.add) begin
            match_found = 1'b1;
            match_wen   = hist_wen[i];
            match_data  = hist_data[i];
            match_be    = hist_be[i];
         end
      end
   end

   assign store_drop = DEDUP_STORES && !tgt.wen && match_found && !match_wen &&
                       match_data == tgt.data && match_be == tgt.be;
   assign load_drop  = DEDUP_LOADS && tgt.wen && hist_valid[0] &&
                       hist_add[0] == tgt.add && hist_wen[0];
   assign drop       = enable_i && (store_drop || load_drop);

   assign tag_empty = tag_cnt == '0;
   assign tag_full  = tag_cnt == CW'(MAX_OUTSTANDING);
   assign tag_head  = tag_mem[tag_rptr];
   assign stall     = tgt.wen && tag_full;

   assign gnt       = !stall && (drop || ini.gnt);
   assign tgt.gnt   = gnt;
   assign ini.req   = tgt.req && !drop && !stall;
   assign handshake = tgt.req && gnt;

   assign hist_clr  = !enable_i || flush_i;
   assign hist_push = handshake && enable_i;

   // history shift register; a push after a clear leaves only the new entry
   for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
      if (gi == 0) begin : g_head
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               hist_valid[0] <= 1'b0;
               hist_add[0]   <= '0;
               hist_wen[0]   <= 1'b0;
               hist_data[0]  <= '0;
               hist_be[0]    <= '0;
            end else begin
               if (hist_clr) hist_valid[0] <= hist_push;
               else if (hist_push) hist_valid[0] <= 1'b1;
               if (hist_push) begin
                  hist_add[0]  <= tgt.add;
                  hist_wen[0]  <= tgt.wen;
                  hist_data[0] <= tgt.data;
                  hist_be[0]   <= tgt.be;
               end
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               hist_valid[gi] <= 1'b0;
               hist_add[gi]   <= '0;
               hist_wen[gi]   <= 1'b0;
               hist_data[gi]  <= '0;
               hist_be[gi]    <= '0;
            end else begin
               if (hist_clr) hist_valid[gi] <= 1'b0;
               else if (hist_push) hist_valid[gi] <= hist_valid[gi-1];
               if (hist_push) begin
                  hist_add[gi]  <= hist_add[gi-1];
                  hist_wen[gi]  <= hist_wen[gi-1];
                  hist_data[gi] <= hist_data[gi-1];
                  hist_be[gi]   <= hist_be[gi-1];
               end
            end
         end
      end
   end

   assign tag_push = handshake && tgt.wen;

   // tag FIFO bookkeeping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_mem  <= '0;
         tag_wptr <= '0;
         tag_rptr <= '0;
         tag_cnt  <= '0;
      end else begin
         if (tag_push) begin
            tag_mem[tag_wptr] <= drop;
            tag_wptr          <= tag_wptr + 1'b1;
         end
         if (resp_hs) tag_rptr <= tag_rptr + 1'b1;
         tag_cnt <= tag_cnt + CW'(tag_push) - CW'(resp_hs);
      end
   end

   // upstream response select: replay last data or buffer head (fall-through)
   always_comb begin
      r_valid = 1'b0;
      r_data  = rbuf_empty ? ini.r_data : rbuf_mem[rbuf_rptr];
      if (!tag_empty) begin
         if (tag_head) begin
            r_valid = 1'b1;
            r_data  = last_data_q;
         end else begin
            r_valid = !rbuf_empty || ini.r_valid;
         end
      end
   end

   assign tgt.r_valid = r_valid;
   assign tgt.r_data  = r_data;
   assign resp_hs     = r_valid && tgt.r_ready;

   assign rbuf_empty = rbuf_cnt == '0;
   assign rbuf_full  = rbuf_cnt == CW'(MAX_OUTSTANDING);
   assign rbuf_pop   = resp_hs && !tag_head;
   assign rbuf_push  = ini.r_valid && !rbuf_full;

   // response buffer storage, no reset needed on the data
   always_ff @(posedge clk_i) begin
      if (rbuf_push) rbuf_mem[rbuf_wptr] <= ini.r_data;
   end

   // response buffer pointers and last delivered data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rbuf_wptr   <= '0;
         rbuf_rptr   <= '0;
         rbuf_cnt    <= '0;
         last_data_q <= '0;
      end else begin
         if (rbuf_push) rbuf_wptr <= rbuf_wptr + 1'b1;
         if (rbuf_pop)  rbuf_rptr <= rbuf_rptr + 1'b1;
         rbuf_cnt <= rbuf_cnt + CW'(rbuf_push) - CW'(rbuf_pop);
         if (resp_hs) last_data_q <= r_data;
      end
   end

   // saturating drop counter, clear has priority
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt_o <= '0;
      end else if (clear_cnt_i) begin
         drop_cnt_o <= '0;
      end else if (handshake && drop && drop_cnt_o != 32'hFFFF_FFFF) begin
         drop_cnt_o <= drop_cnt_o + 32'd1;
      end
   end

   assign busy_o = !tag_empty || !rbuf_empty;
endmodule

// File: tb/tb_redmule_tcdm_dedup_window.sv
// Randomized bench for redmule_tcdm_dedup_window against a queue-based model.
module tb_redmule_tcdm_dedup_window;
   localparam int HIST = 4;
   localparam int MO   = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable, flush, clear_cnt;
   logic [31:0] drop_cnt;
   logic        busy;

   redmule_tcdm_dedup_window_if #(.AW(32), .DW(32)) tgt_if ();
   redmule_tcdm_dedup_window_if #(.AW(32), .DW(32)) ini_if ();

   redmule_tcdm_dedup_window #(
      .AW(32), .DW(32), .HIST_DEPTH(HIST),
      .DEDUP_STORES(1'b1), .DEDUP_LOADS(1'b1), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (enable),
      .flush_i     (flush),
      .clear_cnt_i (clear_cnt),
      .tgt         (tgt_if),
      .ini         (ini_if),
      .drop_cnt_o  (drop_cnt),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] add;
      logic        wen;
      logic [31:0] data;
      logic [3:0]  be;
   } hent_t;

   typedef struct {
      logic        replay;
      logic [31:0] data;
   } exp_t;

   hent_t       hist_q[$];
   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   int          delivered;
   logic [31:0] last_load_data;
   logic [31:0] m_drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // drop decision from the rules: youngest same-address entry for stores,
   // the single most recent entry for loads
   function automatic logic model_drop();
      int   idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      if (!enable) return 1'b0;
      for (int i = 0; i < hist_q.size(); i++) begin
         if (!found && hist_q[i].add == tgt_if.add) begin
            idx   = i;
            found = 1'b1;
         end
      end
      if (!tgt_if.wen)
         return found && !hist_q[idx].wen && hist_q[idx].data == tgt_if.data &&
                hist_q[idx].be == tgt_if.be;
      return hist_q.size() > 0 && hist_q[0].add == tgt_if.add && hist_q[0].wen;
   endfunction

   task automatic do_cycle(input int load_pct, input int rv_pct);
      logic        m_drop, m_stall, m_gnt, m_ireq, e_rv, hs;
      logic [31:0] d;
      int          sel;
      hent_t       h;
      exp_t        e;

      @(negedge clk);
      enable    = ($urandom_range(99) < 95);
      flush     = ($urandom_range(99) < 3);
      clear_cnt = ($urandom_range(99) < 2);
      tgt_if.req = ($urandom_range(99) < 70);
      tgt_if.wen = ($urandom_range(99) < load_pct);
      sel = $urandom_range(2);
      tgt_if.add  = (sel == 0) ? 32'h100 : (sel == 1) ? 32'h104 : 32'h200;
      tgt_if.data = $urandom_range(1) ? 32'hA5 : 32'h5A;
      tgt_if.be   = ($urandom_range(99) < 85) ? 4'hF : 4'h3;
      tgt_if.r_ready = ($urandom_range(99) < 70);
      ini_if.gnt     = ($urandom_range(99) < 80);
      if (mem_q.size() > 0 && $urandom_range(99) < rv_pct) begin
         ini_if.r_valid = 1'b1;
         ini_if.r_data  = mem_q[0];
      end else begin
         ini_if.r_valid = 1'b0;
         ini_if.r_data  = $urandom;
      end
      #1;
      m_drop  = model_drop();
      m_stall = tgt_if.wen && exp_q.size() == MO;
      m_gnt   = !m_stall && (m_drop || ini_if.gnt);
      m_ireq  = tgt_if.req && !m_drop && !m_stall;
      e_rv    = exp_q.size() > 0 && (exp_q[0].replay || delivered > 0 || ini_if.r_valid);

      check_val("drop_cnt", drop_cnt, m_drop_cnt);
      check_val("busy", {31'd0, busy}, {31'd0, (exp_q.size() != 0 || delivered != 0)});
      check_val("ini_req", {31'd0, ini_if.req}, {31'd0, m_ireq});
      if (tgt_if.req) begin
         check_val("tgt_gnt", {31'd0, tgt_if.gnt}, {31'd0, m_gnt});
         check_val("ini_add", ini_if.add, tgt_if.add);
      end
      check_val("r_valid", {31'd0, tgt_if.r_valid}, {31'd0, e_rv});
      if (e_rv) check_val("r_data", tgt_if.r_data, exp_q[0].data);

      @(posedge clk);
      hs = tgt_if.req && m_gnt;
      if (clear_cnt) m_drop_cnt = 0;
      else if (hs && m_drop && m_drop_cnt != 32'hFFFF_FFFF) m_drop_cnt++;
      if (ini_if.r_valid) begin
         delivered++;
         void'(mem_q.pop_front());
      end
      if (e_rv && tgt_if.r_ready) begin
         if (!exp_q[0].replay) delivered--;
         void'(exp_q.pop_front());
      end
      if (hs && tgt_if.wen) begin
         if (m_drop) begin
            e.replay = 1'b1;
            e.data   = last_load_data;
         end else begin
            d = $urandom;
            mem_q.push_back(d);
            e.replay = 1'b0;
            e.data   = d;
            last_load_data = d;
         end
         exp_q.push_back(e);
      end
      if (!enable || flush) hist_q = {};
      if (hs && enable) begin
         h.add  = tgt_if.add;
         h.wen  = tgt_if.wen;
         h.data = tgt_if.data;
         h.be   = tgt_if.be;
         hist_q.push_front(h);
         if (hist_q.size() > HIST) void'(hist_q.pop_back());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b0; flush = 1'b0; clear_cnt = 1'b0;
      tgt_if.req = 1'b0; tgt_if.add = '0; tgt_if.wen = 1'b0;
      tgt_if.data = '0; tgt_if.be = '0; tgt_if.r_ready = 1'b0;
      ini_if.gnt = 1'b0; ini_if.r_valid = 1'b0; ini_if.r_data = '0;
      delivered = 0;
      last_load_data = '0;
      m_drop_cnt = '0;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_drop_cnt", drop_cnt, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_r_valid", {31'd0, tgt_if.r_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 1500 && n_err < 40; c++) do_cycle(50, 60);
      for (int c = 0; c < 400 && n_err < 40; c++) do_cycle(90, 4);
      for (int c = 0; c < 400 && n_err < 40; c++) do_cycle(50, 70);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
